// File: rtl/lock_indicator_pkg.sv
// Shared encodings and defaults for the password-lock output side: state codes,
// default timing constants and the per-state output decode.
package lock_indicator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OK_HOLD = 3'd1,
        ST_ERR_ON  = 3'd2,
        ST_ERR_OFF = 3'd3,
        ST_LOCKED  = 3'd4
    } state_t;

    localparam int DEF_HOLD_CYCLES  = 100_000_000;
    localparam int DEF_BLINK_CYCLES = 25_000_000;
    localparam int DEF_ERR_BLINKS   = 3;
    localparam int DEF_MAX_FAILS    = 3;
    localparam int DEF_CNT_W        = 27;

    typedef struct packed {
        logic led_ok;
        logic led_err;
        logic buzzer;
        logic alarm;
        logic busy;
    } outs_t;

    function automatic outs_t state_outs(input state_t s);
        outs_t o;
        o = '0;
        case (s)
            ST_OK_HOLD: begin o.led_ok = 1'b1; o.busy = 1'b1; end
            ST_ERR_ON:  begin o.led_err = 1'b1; o.buzzer = 1'b1; o.busy = 1'b1; end
            ST_ERR_OFF: o.busy = 1'b1;
            ST_LOCKED:  begin
                o.led_err = 1'b1;
                o.buzzer  = 1'b1;
                o.alarm   = 1'b1;
                o.busy    = 1'b1;
            end
            default:    o = '0;
        endcase
        return o;
    endfunction

    // States in which the shared timer is counting down.
    function automatic logic is_timed(input state_t s);
        return (s == ST_OK_HOLD) || (s == ST_ERR_ON) || (s == ST_ERR_OFF);
    endfunction

endpackage

// File: rtl/lock_indicator_cycle_timer.sv
// Loadable down-counter shared by the OK hold and ERR blink phases; parks at zero
// whenever it is not running so it can never wrap.
module cycle_timer #(
    parameter int CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_run,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (!i_run) begin
            r_cnt <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/lock_indicator.sv
// Turns single-cycle ok/err/clr verdict pulses into timed LED/buzzer signals and
// latches an alarm lockout after MAX_FAILS consecutive failures.
module lock_indicator
    import lock_indicator_pkg::*;
#(
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int BLINK_CYCLES = DEF_BLINK_CYCLES,
    parameter int ERR_BLINKS   = DEF_ERR_BLINKS,
    parameter int MAX_FAILS    = DEF_MAX_FAILS,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic ok_pulse,
    input  logic err_pulse,
    input  logic clr_pulse,
    output logic led_ok,
    output logic led_err,
    output logic buzzer,
    output logic alarm,
    output logic busy
);

    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int IDX_W  = (ERR_BLINKS > 1) ? $clog2(ERR_BLINKS) : 1;

    localparam logic [CNT_W-1:0]  HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  BLINK_LOAD = CNT_W'(BLINK_CYCLES - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX   = FAIL_W'(MAX_FAILS);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(ERR_BLINKS - 1);

    state_t            r_state;
    logic [FAIL_W-1:0] r_fails;
    logic [IDX_W-1:0]  r_idx;
    outs_t             r_out;

    state_t            w_next;
    logic [FAIL_W-1:0] w_fails_next;
    logic [FAIL_W-1:0] w_fails_inc;
    logic [IDX_W-1:0]  w_idx_next;
    logic              w_load;
    logic [CNT_W-1:0]  w_load_val;
    logic              w_run;
    logic              w_expire;

    cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_run      (w_run),
        .o_expire   (w_expire)
    );

    // err has priority over ok; any pulse restarts its sequence from scratch.
    always_comb begin
        w_next       = r_state;
        w_fails_next = r_fails;
        w_idx_next   = r_idx;
        w_load       = 1'b0;
        w_load_val   = BLINK_LOAD;
        w_fails_inc  = (r_fails == FAIL_MAX) ? r_fails : r_fails + 1'b1;

        if (r_state == ST_LOCKED) begin
            if (clr_pulse) begin
                w_next       = ST_IDLE;
                w_fails_next = '0;
            end
        end else if (err_pulse) begin
            w_fails_next = w_fails_inc;
            if (w_fails_inc == FAIL_MAX) begin
                w_next = ST_LOCKED;
            end else begin
                w_next     = ST_ERR_ON;
                w_idx_next = '0;
                w_load     = 1'b1;
            end
        end else if (ok_pulse) begin
            w_fails_next = '0;
            w_next       = ST_OK_HOLD;
            w_load       = 1'b1;
            w_load_val   = HOLD_LOAD;
        end else if (w_expire) begin
            case (r_state)
                ST_OK_HOLD: w_next = ST_IDLE;
                ST_ERR_ON: begin
                    if (r_idx == LAST_IDX) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_next = ST_ERR_OFF;
                        w_load = 1'b1;
                    end
                end
                ST_ERR_OFF: begin
                    w_next     = ST_ERR_ON;
                    w_idx_next = r_idx + 1'b1;
                    w_load     = 1'b1;
                end
                default: w_next = r_state;
            endcase
        end

        w_run = is_timed(w_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_fails <= '0;
            r_idx   <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_next;
            r_fails <= w_fails_next;
            r_idx   <= w_idx_next;
            r_out   <= state_outs(w_next);
        end
    end

    assign led_ok  = r_out.led_ok;
    assign led_err = r_out.led_err;
    assign buzzer  = r_out.buzzer;
    assign alarm   = r_out.alarm;
    assign busy    = r_out.busy;

endmodule

// File: tb/tb_lock_indicator.sv
// Bench for lock_indicator: event/elapsed-time reference model compared every cycle,
// plus literal pattern checks for the hold, blink, lockout and retrigger cases.
module tb_lock_indicator;

    localparam int HOLD  = 8;
    localparam int BLINK = 4;
    localparam int NBL   = 3;
    localparam int MAXF  = 3;
    localparam int ERR_LEN = (2 * NBL - 1) * BLINK;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ok_pulse = 1'b0;
    logic err_pulse = 1'b0;
    logic clr_pulse = 1'b0;
    logic led_ok, led_err, buzzer, alarm, busy;

    int n_asserts = 0;
    int n_fail    = 0;

    // Model: what was the last accepted event and how long ago did its output start.
    int m_fails  = 0;
    bit m_locked = 1'b0;
    int m_mode   = 0;   // 0 none, 1 ok hold, 2 error pattern
    int m_t      = 0;

    logic [20:0] pat;
    logic [8:0]  pat9;

    lock_indicator #(
        .HOLD_CYCLES  (HOLD),
        .BLINK_CYCLES (BLINK),
        .ERR_BLINKS   (NBL),
        .MAX_FAILS    (MAXF),
        .CNT_W        (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ok_pulse  (ok_pulse),
        .err_pulse (err_pulse),
        .clr_pulse (clr_pulse),
        .led_ok    (led_ok),
        .led_err   (led_err),
        .buzzer    (buzzer),
        .alarm     (alarm),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task model_reset();
        m_fails  = 0;
        m_locked = 1'b0;
        m_mode   = 0;
        m_t      = 0;
    endtask

    task model_step(input logic ok, input logic err, input logic clr);
        if (m_locked) begin
            if (clr) begin
                m_locked = 1'b0;
                m_fails  = 0;
                m_mode   = 0;
            end
        end else if (err) begin
            if (m_fails < MAXF) m_fails++;
            if (m_fails == MAXF) begin
                m_locked = 1'b1;
                m_mode   = 0;
            end else begin
                m_mode = 2;
                m_t    = 0;
            end
        end else if (ok) begin
            m_fails = 0;
            m_mode  = 1;
            m_t     = 0;
        end else if (m_mode != 0) begin
            m_t++;
            if (m_mode == 1 && m_t >= HOLD)    m_mode = 0;
            if (m_mode == 2 && m_t >= ERR_LEN) m_mode = 0;
        end
    endtask

    function automatic logic exp_err();
        return m_locked || (m_mode == 2 && ((m_t / BLINK) % 2 == 0));
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("model_led_ok",  32'(led_ok),  32'(!m_locked && m_mode == 1));
            check("model_led_err", 32'(led_err), 32'(exp_err()));
            check("model_buzzer",  32'(buzzer),  32'(exp_err()));
            check("model_alarm",   32'(alarm),   32'(m_locked));
            check("model_busy",    32'(busy),    32'(m_locked || m_mode != 0));
        end
    end

    task automatic tick(input logic ok, input logic err, input logic clr);
        ok_pulse  = ok;
        err_pulse = err;
        clr_pulse = clr;
        @(posedge clk);
        model_step(ok, err, clr);
        @(negedge clk);
        ok_pulse  = 1'b0;
        err_pulse = 1'b0;
        clr_pulse = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1;
        check("reset_outputs", 32'({led_ok, led_err, buzzer, alarm, busy}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // ok hold: exactly HOLD cycles of led_ok, no err activity
        tick(1'b1, 1'b0, 1'b0);
        pat9 = '0;
        for (int i = 0; i < 9; i++) begin
            pat9 = {pat9[7:0], led_ok};
            check("ok_no_err", 32'(led_err), 32'd0);
            if (i < 8) tick(1'b0, 1'b0, 1'b0);
        end
        check("ok_hold_pattern", 32'(pat9), 32'b111111110);

        // single error: 4 on, 4 off, 4 on, 4 off, 4 on, then idle
        tick(1'b0, 1'b1, 1'b0);
        pat = '0;
        for (int i = 0; i < 21; i++) begin
            pat = {pat[19:0], led_err};
            if (i < 20) tick(1'b0, 1'b0, 1'b0);
        end
        check("err_blink_pattern", 32'(pat), 32'b111100001111000011110);
        check("err_idle_after", 32'(busy), 32'd0);

        // second failure, then async reset mid ERR_ON clears everything incl. fail count
        tick(1'b0, 1'b1, 1'b0);
        idle(2);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'({led_ok, led_err, buzzer, alarm, busy}), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // three failures lock; ok ignored; clr unlocks; next err counts as 1
        tick(1'b0, 1'b1, 1'b0); idle(ERR_LEN);
        tick(1'b0, 1'b1, 1'b0); idle(ERR_LEN);
        check("two_fails_no_alarm", 32'(alarm), 32'd0);
        tick(1'b0, 1'b1, 1'b0);
        check("lock_outputs", 32'({alarm, led_err, buzzer, busy}), 32'hF);
        tick(1'b1, 1'b0, 1'b0);
        check("lock_ignores_ok", 32'({led_ok, alarm}), 32'b01);
        tick(1'b0, 1'b1, 1'b0);
        idle(3);
        check("lock_steady", 32'({alarm, led_err, buzzer}), 32'h7);
        tick(1'b0, 1'b0, 1'b1);
        check("clr_outputs", 32'({led_ok, led_err, buzzer, alarm, busy}), 32'd0);
        tick(1'b0, 1'b1, 1'b0);
        check("after_clr_err", 32'({alarm, led_err}), 32'b01);
        idle(ERR_LEN);
        tick(1'b0, 1'b1, 1'b0); idle(ERR_LEN);
        check("after_clr_count2", 32'(alarm), 32'd0);

        // ok clears the consecutive-fail count
        tick(1'b1, 1'b0, 1'b0); idle(HOLD);
        tick(1'b0, 1'b1, 1'b0); idle(ERR_LEN);
        tick(1'b1, 1'b0, 1'b0); idle(HOLD);
        tick(1'b0, 1'b1, 1'b0); idle(ERR_LEN);
        tick(1'b0, 1'b1, 1'b0); idle(ERR_LEN);
        check("ok_cleared_count", 32'(alarm), 32'd0);

        // simultaneous ok+err: err wins
        tick(1'b1, 1'b0, 1'b0); idle(HOLD);
        tick(1'b1, 1'b1, 1'b0);
        check("ok_err_same_cycle", 32'({led_ok, led_err}), 32'b01);
        idle(ERR_LEN);

        // ok during ERR_OFF retriggers a full hold
        tick(1'b1, 1'b0, 1'b0); idle(HOLD);
        tick(1'b0, 1'b1, 1'b0);
        idle(5);
        check("in_err_off", 32'({led_err, busy}), 32'b01);
        tick(1'b1, 1'b0, 1'b0);
        pat9 = '0;
        for (int i = 0; i < 9; i++) begin
            pat9 = {pat9[7:0], led_ok};
            check("retrig_ok_no_err", 32'(led_err), 32'd0);
            if (i < 8) tick(1'b0, 1'b0, 1'b0);
        end
        check("retrig_ok_pattern", 32'(pat9), 32'b111111110);

        // err during OK_HOLD restarts the blink pattern from index 0
        tick(1'b1, 1'b0, 1'b0);
        idle(3);
        tick(1'b0, 1'b1, 1'b0);
        pat = '0;
        for (int i = 0; i < 21; i++) begin
            pat = {pat[19:0], buzzer};
            check("retrig_err_no_ok", 32'(led_ok), 32'd0);
            if (i < 20) tick(1'b0, 1'b0, 1'b0);
        end
        check("retrig_err_pattern", 32'(pat), 32'b111100001111000011110);

        // clr outside LOCKED has no effect
        tick(1'b0, 1'b0, 1'b1);
        check("clr_idle_noop", 32'({busy, alarm}), 32'd0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
